// File: rtl/alu_pipe_pkg.sv
// AluCntrl operation encoding shared by the ALU pipe and its combinational core.
package control_signals;

    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD      = 4'd0,
        ALU_SUB      = 4'd1,
        ALU_SHIFT_LL = 4'd2,
        ALU_SHIFT_RL = 4'd3,
        ALU_SHIFT_RA = 4'd4,
        ALU_SET_LT   = 4'd5,
        ALU_SET_LTU  = 4'd6,
        ALU_XOR      = 4'd7,
        ALU_OR       = 4'd8,
        ALU_AND      = 4'd9,
        ALU_PASS_A   = 4'd10,
        ALU_PASS_B   = 4'd11,
        ALU_PC_INC   = 4'd12
    } AluCntrl;

    localparam AluCntrl ALU_LAST_LEGAL = ALU_PC_INC;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational AluCntrl datapath: (op, a, b) -> (result, err). Optional
// status flags are built only when ALU_PIPE_FLAGS_EN is defined.
module alu_core
    import control_signals::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PC_INC_STEP = 4
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH-1:0]    result,
    output logic                err
`ifdef ALU_PIPE_FLAGS_EN
   ,output logic                zero,
    output logic                neg,
    output logic                carry,
    output logic                ovf
`endif
);

    localparam int unsigned SHW = $clog2(WIDTH);
    // Adders carry an extra bit only when the carry flag needs it.
`ifdef ALU_PIPE_FLAGS_EN
    localparam int unsigned EW = WIDTH + 1;
`else
    localparam int unsigned EW = WIDTH;
`endif

    logic [SHW-1:0] shamt;
    logic [EW-1:0]  sum;
    logic [EW-1:0]  diff;
    logic [EW-1:0]  inc;

    assign shamt = b[SHW-1:0];
    assign sum   = EW'(a) + EW'(b);
    assign diff  = EW'(a) + EW'(~b) + EW'(1);
    assign inc   = EW'(a) + EW'(PC_INC_STEP);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            ALU_ADD:      result = sum[WIDTH-1:0];
            ALU_SUB:      result = diff[WIDTH-1:0];
            ALU_SHIFT_LL: result = a << shamt;
            ALU_SHIFT_RL: result = a >> shamt;
            ALU_SHIFT_RA: result = $signed(a) >>> shamt;
            ALU_SET_LT:   result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SET_LTU:  result = {{(WIDTH-1){1'b0}}, a < b};
            ALU_XOR:      result = a ^ b;
            ALU_OR:       result = a | b;
            ALU_AND:      result = a & b;
            ALU_PASS_A:   result = a;
            ALU_PASS_B:   result = b;
            ALU_PC_INC:   result = inc[WIDTH-1:0];
            default:      err    = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_FLAGS_EN
    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_INC_STEP);

    assign zero = (result == '0);
    assign neg  = result[WIDTH-1];

    // SUB carry is the no-borrow bit of a + ~b + 1.
    always_comb begin
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            ALU_ADD: begin
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                carry = diff[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_PC_INC: begin
                carry = inc[WIDTH];
                ovf   = (a[WIDTH-1] == STEP[WIDTH-1]) && (inc[WIDTH-1] != a[WIDTH-1]);
            end
            default: ;
        endcase
    end
`endif

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipe with tag passthrough and illegal-op flagging.
// Define ALU_PIPE_FLAGS_EN to add registered zero/neg/carry/ovf outputs.
module alu_pipe
    import control_signals::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned PC_INC_STEP = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_result,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err
`ifdef ALU_PIPE_FLAGS_EN
   ,output logic                out_zero,
    output logic                out_neg,
    output logic                out_carry,
    output logic                out_ovf
`endif
);

    logic                valid_s1;
    logic                valid_s2;
    logic [ALU_OP_W-1:0] op_s1;
    logic [WIDTH-1:0]    a_s1;
    logic [WIDTH-1:0]    b_s1;
    logic [TAG_W-1:0]    tag_s1;
    logic                rdy1;
    logic                rdy2;
    logic [WIDTH-1:0]    core_result;
    logic                core_err;
`ifdef ALU_PIPE_FLAGS_EN
    logic                core_zero;
    logic                core_neg;
    logic                core_carry;
    logic                core_ovf;
`endif

    // An empty stage always accepts, so bubbles collapse under backpressure.
    assign rdy2      = !valid_s2 || out_ready;
    assign rdy1      = !valid_s1 || rdy2;
    assign in_ready  = rdy1;
    assign out_valid = valid_s2;

    alu_core #(
        .WIDTH       (WIDTH),
        .PC_INC_STEP (PC_INC_STEP)
    ) u_core (
        .op     (op_s1),
        .a      (a_s1),
        .b      (b_s1),
        .result (core_result),
        .err    (core_err)
`ifdef ALU_PIPE_FLAGS_EN
       ,.zero   (core_zero),
        .neg    (core_neg),
        .carry  (core_carry),
        .ovf    (core_ovf)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1 <= 1'b0;
            op_s1    <= '0;
            a_s1     <= '0;
            b_s1     <= '0;
            tag_s1   <= '0;
        end else if (rdy1) begin
            valid_s1 <= in_valid;
            if (in_valid) begin
                op_s1  <= in_op;
                a_s1   <= in_a;
                b_s1   <= in_b;
                tag_s1 <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s2   <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
`ifdef ALU_PIPE_FLAGS_EN
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
`endif
        end else if (rdy2) begin
            valid_s2 <= valid_s1;
            if (valid_s1) begin
                out_result <= core_result;
                out_tag    <= tag_s1;
                out_err    <= core_err;
`ifdef ALU_PIPE_FLAGS_EN
                out_zero   <= core_zero;
                out_neg    <= core_neg;
                out_carry  <= core_carry;
                out_ovf    <= core_ovf;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expected results are queued on accept and
// compared on each output transfer.
module tb_alu_pipe;
    import control_signals::*;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = '0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;
    logic          out_err;
`ifdef ALU_PIPE_FLAGS_EN
    logic          out_zero, out_neg, out_carry, out_ovf;
`endif

    alu_pipe #(.WIDTH(W), .TAG_W(TW), .PC_INC_STEP(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err)
`ifdef ALU_PIPE_FLAGS_EN
       ,.out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        logic          err;
        logic [3:0]    flags;   // {zero, neg, carry, ovf}
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [TW-1:0] tag);
        exp_t        e;
        logic [63:0] wide;
        longint      ss;
        int          sh;
        logic        carry, ovf;
        sh    = int'(b[4:0]);
        carry = 1'b0;
        ovf   = 1'b0;
        e.tag = tag;
        e.err = 1'b0;
        e.res = '0;
        case (op)
            ALU_ADD: begin
                wide  = 64'(a) + 64'(b);
                e.res = wide[31:0];
                carry = wide[32];
                ss    = longint'($signed(a)) + longint'($signed(b));
                ovf   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            ALU_SUB: begin
                e.res = a - b;
                carry = (a >= b);
                ss    = longint'($signed(a)) - longint'($signed(b));
                ovf   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            ALU_SHIFT_LL: e.res = a << sh;
            ALU_SHIFT_RL: e.res = a >> sh;
            ALU_SHIFT_RA: e.res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            ALU_SET_LT:   e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            ALU_SET_LTU:  e.res = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:      e.res = a ^ b;
            ALU_OR:       e.res = a | b;
            ALU_AND:      e.res = a & b;
            ALU_PASS_A:   e.res = a;
            ALU_PASS_B:   e.res = b;
            ALU_PC_INC: begin
                wide  = 64'(a) + 64'd4;
                e.res = wide[31:0];
                carry = wide[32];
                ss    = longint'($signed(a)) + 64'sd4;
                ovf   = ss > 64'sd2147483647;
            end
            default:      e.err = 1'b1;
        endcase
        e.flags = {e.res == 32'h0, e.res[31], carry, ovf};
        return e;
    endfunction

    int   cyc = 0;
    int   pop_cnt = 0;
    int   acc_cnt = 0;
    int   last_pop = 0;
    bit   gap_chk = 0;
    bit   gap_seen = 0;
    exp_t e_mon;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e_mon = sb_q.pop_front();
                    check_val("result", out_result, e_mon.res);
                    check_val("tag", out_tag, e_mon.tag);
                    check_val("err", out_err, e_mon.err);
`ifdef ALU_PIPE_FLAGS_EN
                    check_val("flags", {out_zero, out_neg, out_carry, out_ovf}, e_mon.flags);
`endif
                end
                if (gap_chk) begin
                    if (gap_seen) check_val("stream_gap", 64'(cyc - last_pop), 64'd1);
                    gap_seen = 1'b1;
                end
                last_pop = cyc;
                pop_cnt++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(in_op, in_a, in_b, in_tag));
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check_val("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_op    = '0;
        in_a     = '0;
        in_b     = '0;
        in_tag   = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check_val("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycles=%0d required<20000", cyc);
        $fatal(1);
    end

    int            p0, a0;
    logic [W-1:0]  snap_res;
    logic [TW-1:0] snap_tag;
    logic          snap_err;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_result", out_result, 0);
        check_val("rst_tag", out_tag, 0);
        check_val("rst_err", out_err, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // wrap-around add, accepted in the first cycle after reset
        send(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 5'd1);
        idle();
        check_val("lat_cycle1", out_valid, 0);
        @(posedge clk);
        #1;
        check_val("lat_cycle2", out_valid, 1);
        check_val("add_wrap", out_result, 0);
        drain();

        // shifts / compares, then every legal op with random operands
        send(ALU_SHIFT_RA, 32'h8000_0000, 32'h24, 5'd2);
        send(ALU_SET_LT,   32'hFFFF_FFFF, 32'h1,  5'd3);
        send(ALU_SET_LTU,  32'hFFFF_FFFF, 32'h1,  5'd4);
        send(ALU_SUB,      32'h5,         32'h7,  5'd5);
        send(ALU_PC_INC,   32'h7FFF_FFFE, 32'h0,  5'd6);
        for (int op = 0; op <= 12; op++)
            send(4'(op), $urandom, $urandom, 5'(op + 8));
        idle();
        drain();

        // back-to-back stream at full rate
        p0       = pop_cnt;
        gap_chk  = 1'b1;
        gap_seen = 1'b0;
        for (int i = 0; i < 10; i++)
            send(ALU_ADD, 32'(i * 3), 32'(1000 + i), 5'(i));
        idle();
        drain();
        gap_chk = 1'b0;
        check_val("stream_count", 64'(pop_cnt - p0), 64'd10);

        // backpressure: pipe fills after two accepts, outputs hold
        p0        = pop_cnt;
        a0        = acc_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(ALU_XOR, 32'(i * 100), 32'h5A5A, 5'(20 + i));
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                snap_res = out_result;
                snap_tag = out_tag;
                snap_err = out_err;
                check_val("stall_valid", out_valid, 1);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    check_val("stall_result", out_result, snap_res);
                    check_val("stall_tag", out_tag, snap_tag);
                    check_val("stall_err", out_err, snap_err);
                end
                check_val("stall_accepts", 64'(acc_cnt - a0), 64'd2);
                check_val("stall_in_ready", in_ready, 0);
                out_ready = 1'b1;
            end
        join
        drain();
        check_val("stall_count", 64'(pop_cnt - p0), 64'd4);

        // illegal op code, then a legal op clears err
        send(4'hE, 32'h1234, 32'h5678, 5'h1F);
        send(ALU_OR, 32'h00F0, 32'h0F00, 5'h02);
        idle();
        drain();

        // reset mid-stall with two ops in flight
        out_ready = 1'b0;
        send(ALU_ADD, 32'h11, 32'h22, 5'd7);
        send(ALU_AND, 32'hFF, 32'h0F, 5'd8);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", out_valid, 0);
        check_val("mid_rst_in_ready", in_ready, 1);
        check_val("mid_rst_result", out_result, 0);
        check_val("mid_rst_tag", out_tag, 0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        p0        = pop_cnt;
        repeat (3) @(posedge clk);
        #1;
        check_val("post_rst_no_stale", out_valid, 0);
        send(ALU_PASS_B, 32'h0, 32'hCAFE, 5'd9);
        idle();
        drain();
        check_val("post_rst_count", 64'(pop_cnt - p0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
